phy_rx: RTL



---
 rtl/phy_rx_pkg.sv | 12 +
 rtl/phy_rx_sipo.sv | 27 ++
 rtl/phy_rx.sv | 130 +++++++++++++
 3 files changed

// File: rtl/phy_rx_pkg.sv
// Shared symbols, FSM state encoding and lane count for the phy_rx serial receiver.
package phy_rx_pkg;
   localparam int         NUM_LANES = 4;
   localparam logic [7:0] COM       = 8'hBC;
   localparam logic [7:0] PAD       = 8'hF7;

   typedef enum logic [1:0] {UNLOCKED, ALIGN, LOCKED} state_e;

   function automatic logic slot_valid(input logic [7:0] b);
      return b != PAD;
   endfunction
endpackage

// File: rtl/phy_rx_sipo.sv
// Bit-serial front end: shift register plus byte-phase counter producing the candidate byte.
module phy_rx_sipo (
   input  logic       clk,
   input  logic       reset,
   input  logic       data_i,
   input  logic       hold_i,
   output logic [7:0] cand_o,
   output logic       byte_done_o
);
   // Only the seven most recent bits are kept; the eighth is the live line bit.
   logic [6:0] shreg_q;
   logic [2:0] bit_cnt_q, bit_cnt_d;

   assign cand_o      = {shreg_q, data_i};
   assign byte_done_o = (bit_cnt_q == 3'd7);
   assign bit_cnt_d   = hold_i ? 3'd0 : bit_cnt_q + 3'd1;

   always_ff @(posedge clk) begin
      if (reset) begin
         shreg_q   <= '0;
         bit_cnt_q <= '0;
      end else begin
         shreg_q   <= cand_o[6:0];
         bit_cnt_q <= bit_cnt_d;
      end
   end
endmodule

// File: rtl/phy_rx.sv
// Four-lane byte-striped PHY receiver: COM-based alignment, slot reassembly, word publish.
// Optional PHY_RX_LOCK_LOSS_EN: a framing error drops lock and forces a full relock.
module phy_rx
   import phy_rx_pkg::*;
#(
   parameter int LOCK_COMS = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       data_in,
   output logic [7:0] data_out0,
   output logic [7:0] data_out1,
   output logic [7:0] data_out2,
   output logic [7:0] data_out3,
   output logic       valid_out0,
   output logic       valid_out1,
   output logic       valid_out2,
   output logic       valid_out3,
   output logic       frame_stb,
   output logic       locked,
   output logic       frame_err
);
   localparam logic [3:0] LOCK_LAST = 4'(LOCK_COMS - 1);

   logic [7:0] cand;
   logic       byte_done;

   state_e                          state_q;
   logic [3:0]                      com_cnt_q;
   logic [1:0]                      lane_idx_q;
   logic [NUM_LANES-2:0][7:0]       stage_q;
   logic [NUM_LANES-1:0][7:0]       data_q;
   logic [NUM_LANES-1:0]            vld_q;
   logic                            stb_q, err_q, locked_q;

   phy_rx_sipo u_sipo (
      .clk        (clk),
      .reset      (reset),
      .data_i     (data_in),
      .hold_i     (state_q == UNLOCKED),
      .cand_o     (cand),
      .byte_done_o(byte_done)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= UNLOCKED;
         com_cnt_q  <= '0;
         lane_idx_q <= '0;
         stage_q    <= '0;
         data_q     <= '0;
         vld_q      <= '0;
         stb_q      <= 1'b0;
         err_q      <= 1'b0;
         locked_q   <= 1'b0;
      end else begin
         stb_q <= 1'b0;
         err_q <= 1'b0;
         case (state_q)
            UNLOCKED: begin
               if (cand == COM) begin
                  state_q   <= ALIGN;
                  com_cnt_q <= 4'd1;
               end
            end
            ALIGN: begin
               if (byte_done) begin
                  if (cand == COM) begin
                     com_cnt_q <= com_cnt_q + 4'd1;
                     if (com_cnt_q == LOCK_LAST) begin
                        state_q    <= LOCKED;
                        locked_q   <= 1'b1;
                        lane_idx_q <= '0;
                     end
                  end else begin
                     state_q   <= UNLOCKED;
                     com_cnt_q <= '0;
                  end
               end
            end
            LOCKED: begin
               if (byte_done) begin
                  if (lane_idx_q == 2'd0) begin
                     // COM in slot 0 is idle fill; anything else opens a frame.
                     if (cand != COM) begin
                        stage_q[0] <= cand;
                        lane_idx_q <= 2'd1;
                     end
                  end else if (cand == COM) begin
                     err_q      <= 1'b1;
                     lane_idx_q <= '0;
`ifdef PHY_RX_LOCK_LOSS_EN
                     state_q   <= UNLOCKED;
                     locked_q  <= 1'b0;
                     com_cnt_q <= '0;
`else
                     state_q   <= LOCKED;
`endif
                  end else if (lane_idx_q == 2'd3) begin
                     for (int l = 0; l < NUM_LANES - 1; l++) begin
                        data_q[l] <= stage_q[l];
                        vld_q[l]  <= slot_valid(stage_q[l]);
                     end
                     data_q[3]  <= cand;
                     vld_q[3]   <= slot_valid(cand);
                     stb_q      <= 1'b1;
                     lane_idx_q <= '0;
                  end else begin
                     stage_q[lane_idx_q] <= cand;
                     lane_idx_q          <= lane_idx_q + 2'd1;
                  end
               end
            end
            default: state_q <= UNLOCKED;
         endcase
      end
   end

   assign data_out0  = data_q[0];
   assign data_out1  = data_q[1];
   assign data_out2  = data_q[2];
   assign data_out3  = data_q[3];
   assign valid_out0 = vld_q[0];
   assign valid_out1 = vld_q[1];
   assign valid_out2 = vld_q[2];
   assign valid_out3 = vld_q[3];
   assign frame_stb  = stb_q;
   assign frame_err  = err_q;
   assign locked     = locked_q;
endmodule
